sar_conv_ctrl: RTL
==================

# sar_conv_ctrl

Successive-approximation conversion controller for the SAR ADC. It consumes the start window produced by the sample-clock start-pulse generator and drives the external R-2R DAC code, one trial bit at a time. Each trial is judged from the external comparator, and the block delivers the finished code with a one-cycle valid strobe. It runs entirely in the fast `clk1` domain, between the start-pulse generator and the downstream sample capture/display logic.

## Interface
Parameters:
- `BITS`, default 8: resolution; width of the DAC code and the result.
- `SETTLE`, default 20: `clk1` cycles allowed per trial for DAC and comparator settling. Must be ≥ 3 to cover the comparator synchronizer.

Ports:
- `clk1`, in, 1: the single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: start window from the start-pulse generator. A conversion begins on its rising edge.
- `comp`, in, 1: external comparator, asynchronous. 1 means Vin ≥ Vdac.
- `dac`, out, BITS: trial code to the external DAC.
- `hold`, out, 1: sample-and-hold command, high while converting.
- `busy`, out, 1: conversion in progress.
- `data`, out, BITS: last completed conversion result.
- `valid`, out, 1: one-cycle strobe when `data` updates.

## Operation
- The comparator passes through a 2-flop synchronizer, `comp_s`, with both flops resetting to 0.
- Start edge detect: a register `last_start` holds the previous value of `start`. A rise is `start & ~last_start`.
  - `last_start` resets to 1, so a `start` already high at reset release does not trigger a conversion.
- States:
  - IDLE → SETTLE on a start rise. On that transition: `dac` = 1<<(BITS-1), `idx` = BITS-1, `cnt` = 0, `busy` = 1, `hold` = 1.
  - SETTLE: `cnt` increments each cycle. When `cnt` == SETTLE-1, the next state is DECIDE.
  - DECIDE, one cycle: if `comp_s` == 0, clear `dac[idx]`; otherwise keep it.
    - If `idx` > 0: set `dac[idx-1]`, decrement `idx`, set `cnt` = 0, go to SETTLE.
    - If `idx` == 0: `data` ← final code (including this decision), `valid` = 1, `busy` = 0, `hold` = 0, go to IDLE.
- `valid` clears on the next cycle.
- `dac` keeps the final code in IDLE until the next conversion loads its MSB trial.
- `data` holds its value until the next completion.
- Start rises during SETTLE or DECIDE are ignored, and no restart occurs. `last_start` keeps tracking `start` in every state.
- A start rise in the cycle where `valid` is high (state is IDLE) is accepted.
- Widths:
  - `cnt` is wide enough for SETTLE-1 and never wraps.
  - `idx` is ceil(log2(BITS)) wide, minimum 1.
  - No arithmetic on `dac`: only single-bit set and clear.

## Timing
- Reset values: `dac`, `data`, `valid`, `busy` and `hold` are all 0; state is IDLE; `cnt` and `idx` are 0; synchronizer flops are 0; `last_start` is 1.
- Asserting `rst_n` low mid-conversion clears everything immediately, asynchronously. No `valid` is produced for the aborted conversion.
- Let T0 be the edge at which the start rise is seen:
  - After T0: `busy`, `hold` and `dac` = MSB trial are visible.
  - Each bit takes SETTLE+1 edges: SETTLE edges in SETTLE, then 1 edge in DECIDE.
  - `valid` is high after edge T0 + BITS·(SETTLE+1), which is 168 edges for the defaults, for exactly one cycle.
  - `busy` and `hold` fall at that same edge.
- The `comp` value used for bit `idx` is the synchronized value at the DECIDE edge, reflecting `comp` from 2 cycles earlier.
- Each DAC code is stable for SETTLE+1 cycles before the next change.

## Test plan
1. **Reset.** Hold `rst_n` low with `start` = 1, then release → all outputs stay 0 and no conversion starts. Then pulse `rst_n` low at T0+50 of a running conversion → outputs are 0 asynchronously, and `valid` is never asserted.
2. **Mid-scale code.** Comparator model `comp` = (`dac` ≤ 0xA5), one start rise →
   - `dac` trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each held 21 cycles;
   - `data` = 0xA5 with `valid` high for 1 cycle at T0+168.
3. **Extremes.** `comp` tied to 0 → `data` = 0x00. `comp` tied to 1 → `data` = 0xFF. Both with 168-cycle latency.
4. **Ignored restarts.** Extra start rises at T0+30 and T0+100 → `dac` sequence and `data` are identical to scenario 2, and exactly one `valid` occurs. Holding `start` high for 400 cycles → only one conversion.
5. **Back-to-back.** Start rise coincident with the `valid` cycle, with a new Vin code of 0x3C → `busy` re-asserts on the next cycle, `dac` = 0x80, and the second `valid` arrives 168 cycles later with `data` = 0x3C.
6. **Synchronizer latency.** With `SETTLE` = 3, flip `comp` 1 cycle before a DECIDE edge → the decision uses the old value. Flipping it 2 cycles before → the decision uses the new value.

Source files
------------

// File: rtl/sar_conv_ctrl_if.sv
// Signal bundle between the SAR conversion controller and its environment:
// start window and comparator in, DAC trial code and result out.
interface sar_conv_ctrl_if #(
  parameter int BITS = 8
);
  logic            start;
  logic            comp;
  logic [BITS-1:0] dac;
  logic            hold;
  logic            busy;
  logic [BITS-1:0] data;
  logic            valid;

  // Environment side: drives start/comp, observes the controller.
  modport master (
    output start, comp,
    input  dac, hold, busy, data, valid
  );

  // Controller side.
  modport slave (
    input  start, comp,
    output dac, hold, busy, data, valid
  );
endinterface

// File: rtl/sar_conv_ctrl.sv
// Successive-approximation conversion controller. Walks one trial bit per
// step from MSB to LSB, lets the DAC/comparator settle for SETTLE cycles,
// then keeps or clears the trial bit from the synchronized comparator.
module sar_conv_ctrl #(
  parameter int BITS   = 8,
  parameter int SETTLE = 20
) (
  input  logic             clk1,
  input  logic             rst_n,
  sar_conv_ctrl_if.slave   bus
);

  localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1;
  // Wide enough to hold SETTLE-1; the counter stops there, so it never wraps.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DECIDE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BITS-1:0]  dac_q, dac_d;
  logic [BITS-1:0]  data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             hold_q, hold_d;
  logic             last_start_q, last_start_d;
  logic             comp_meta_q, comp_meta_d;
  logic             comp_s_q, comp_s_d;
  logic             start_rise;

  assign bus.dac   = dac_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.hold  = hold_q;

  // Next-state and datapath: edge detect, settle count, bit decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dac_d        = dac_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;
    hold_d       = hold_q;
    last_start_d = bus.start;
    comp_meta_d  = bus.comp;
    comp_s_d     = comp_meta_q;
    start_rise   = bus.start & ~last_start_q;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d         = S_SETTLE;
          dac_d           = '0;
          dac_d[BITS-1]   = 1'b1;
          idx_d           = IDX_MSB;
          cnt_d           = '0;
          busy_d          = 1'b1;
          hold_d          = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECIDE: begin
        // Comparator low means Vin is below the trial level: drop the bit.
        if (!comp_s_q) begin
          dac_d[idx_q] = 1'b0;
        end
        if (idx_q != '0) begin
          dac_d[idx_q - 1'b1] = 1'b1;
          idx_d               = idx_q - 1'b1;
          cnt_d               = '0;
          state_d             = S_SETTLE;
        end else begin
          data_d  = dac_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          hold_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Comparator synchronizer and start-history register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      comp_meta_q  <= 1'b0;
      comp_s_q     <= 1'b0;
      last_start_q <= 1'b1;  // a start already high at reset release is not a rise
    end else begin
      comp_meta_q  <= comp_meta_d;
      comp_s_q     <= comp_s_d;
      last_start_q <= last_start_d;
    end
  end

  // Controller state and output registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dac_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dac_q   <= dac_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

endmodule
